// File: rtl/mc_control_fsm.sv
// Main control FSM for the multi-cycle MIPS datapath: sequences each instruction and drives mux selects and enables.
// Optional jal support is built when MC_CONTROL_JAL_EN is defined.
module mc_control_fsm (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opcode,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       i_or_d,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       mem_to_reg,
  output logic [1:0] reg_dst,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] pc_source,
  output logic       pc_to_reg,
  output logic       illegal_op,
  output logic [3:0] state
);

  // state  | meaning
  // FETCH  | read instruction, PC <= PC+4
  // DECODE | register read, branch target precompute
  // MEMADR | address = A + sign-ext imm
  // MEMRD  | data memory read
  // MEMWB  | rt <= MDR
  // MEMWR  | data memory write
  // EXEC   | R-type ALU operation
  // ALUWB  | rd <= ALUOut
  // BRANCH | compare, PC <= target if zero
  // JUMP   | PC <= jump target
  // ADDIEX | A + sign-ext imm
  // ADDIWB | rt <= ALUOut
  // JAL    | r31 <= PC, PC <= jump target
  typedef enum logic [3:0] {
    ST_FETCH  = 4'd0,
    ST_DECODE = 4'd1,
    ST_MEMADR = 4'd2,
    ST_MEMRD  = 4'd3,
    ST_MEMWB  = 4'd4,
    ST_MEMWR  = 4'd5,
    ST_EXEC   = 4'd6,
    ST_ALUWB  = 4'd7,
    ST_BRANCH = 4'd8,
    ST_JUMP   = 4'd9,
    ST_ADDIEX = 4'd10,
    ST_ADDIWB = 4'd11,
    ST_JAL    = 4'd12
  } state_t;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_JAL  = 6'b000011;

  state_t state_q, state_d;
  logic   op_legal;

  always_comb begin
    op_legal = 1'b0;
    case (opcode)
      OP_R, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI: op_legal = 1'b1;
`ifdef MC_CONTROL_JAL_EN
      OP_JAL: op_legal = 1'b1;
`endif
      default: op_legal = 1'b0;
    endcase
  end

  always_comb begin
    state_d = ST_FETCH;
    case (state_q)
      ST_FETCH:  state_d = ST_DECODE;
      ST_DECODE: begin
        case (opcode)
          OP_LW, OP_SW: state_d = ST_MEMADR;
          OP_R:         state_d = ST_EXEC;
          OP_BEQ:       state_d = ST_BRANCH;
          OP_J:         state_d = ST_JUMP;
          OP_ADDI:      state_d = ST_ADDIEX;
`ifdef MC_CONTROL_JAL_EN
          OP_JAL:       state_d = ST_JAL;
`endif
          default:      state_d = ST_FETCH;
        endcase
      end
      ST_MEMADR: state_d = (opcode == OP_SW) ? ST_MEMWR : ST_MEMRD;
      ST_MEMRD:  state_d = ST_MEMWB;
      ST_EXEC:   state_d = ST_ALUWB;
      ST_ADDIEX: state_d = ST_ADDIWB;
      default:   state_d = ST_FETCH;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_FETCH;
    else     state_q <= state_d;
  end

  // Outputs follow the registered state; reset masks them so no strobe leaks while held.
  always_comb begin
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    i_or_d        = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    mem_to_reg    = 1'b0;
    reg_dst       = 2'b00;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    alu_op        = 2'b00;
    pc_source     = 2'b00;
    pc_to_reg     = 1'b0;
    illegal_op    = 1'b0;
    if (!rst) begin
      case (state_q)
        ST_FETCH: begin
          mem_read  = 1'b1;
          ir_write  = 1'b1;
          alu_src_b = 2'b01;
          pc_write  = 1'b1;
        end
        ST_DECODE: begin
          alu_src_b  = 2'b11;
          illegal_op = !op_legal;
        end
        ST_MEMADR, ST_ADDIEX: begin
          alu_src_a = 1'b1;
          alu_src_b = 2'b10;
        end
        ST_MEMRD: begin
          mem_read = 1'b1;
          i_or_d   = 1'b1;
        end
        ST_MEMWB: begin
          reg_write  = 1'b1;
          mem_to_reg = 1'b1;
        end
        ST_MEMWR: begin
          mem_write = 1'b1;
          i_or_d    = 1'b1;
        end
        ST_EXEC: begin
          alu_src_a = 1'b1;
          alu_op    = 2'b10;
        end
        ST_ALUWB: begin
          reg_write = 1'b1;
          reg_dst   = 2'b01;
        end
        ST_BRANCH: begin
          alu_src_a     = 1'b1;
          alu_op        = 2'b01;
          pc_write_cond = 1'b1;
          pc_source     = 2'b01;
        end
        ST_JUMP: begin
          pc_write  = 1'b1;
          pc_source = 2'b10;
        end
        ST_ADDIWB: reg_write = 1'b1;
`ifdef MC_CONTROL_JAL_EN
        ST_JAL: begin
          pc_write  = 1'b1;
          pc_source = 2'b10;
          reg_write = 1'b1;
          reg_dst   = 2'b10;
          pc_to_reg = 1'b1;
        end
`endif
        default: ;
      endcase
    end
  end

  assign state = state_q;

endmodule

// File: tb/tb_mc_control_fsm.sv
// Randomized self-checking bench for mc_control_fsm against an instruction-level sequence model.
module tb_mc_control_fsm;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] opcode;
  logic       pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
  logic       mem_to_reg, reg_write, alu_src_a, pc_to_reg, illegal_op;
  logic [1:0] reg_dst, alu_src_b, alu_op, pc_source;
  logic [3:0] state;

  int checks = 0;
  int failures = 0;
  int seq_q[$];

`ifdef MC_CONTROL_JAL_EN
  localparam bit JAL_EN = 1'b1;
`else
  localparam bit JAL_EN = 1'b0;
`endif

  mc_control_fsm dut (
    .clk(clk), .rst(rst), .opcode(opcode),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .i_or_d(i_or_d),
    .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
    .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .pc_source(pc_source), .pc_to_reg(pc_to_reg), .illegal_op(illegal_op),
    .state(state)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1);
  end

  logic [18:0] outs;
  assign outs = {pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
                 mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
                 pc_source, pc_to_reg, illegal_op};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit is_legal(input logic [5:0] op);
    return (op == 6'b000000) || (op == 6'b100011) || (op == 6'b101011) ||
           (op == 6'b000100) || (op == 6'b000010) || (op == 6'b001000) ||
           (JAL_EN && op == 6'b000011);
  endfunction

  // Expected control word for each state, straight from the per-state table.
  function automatic logic [18:0] exp_out(input int st, input logic [5:0] op);
    logic pw = 0, pwc = 0, iod = 0, mr = 0, mw = 0, irw = 0, m2r = 0, rw = 0, asa = 0, p2r = 0, ill = 0;
    logic [1:0] rd = 0, asb = 0, aop = 0, psrc = 0;
    case (st)
      0:  begin mr = 1; irw = 1; asb = 2'b01; pw = 1; end
      1:  begin asb = 2'b11; ill = !is_legal(op); end
      2:  begin asa = 1; asb = 2'b10; end
      3:  begin mr = 1; iod = 1; end
      4:  begin rw = 1; m2r = 1; end
      5:  begin mw = 1; iod = 1; end
      6:  begin asa = 1; aop = 2'b10; end
      7:  begin rw = 1; rd = 2'b01; end
      8:  begin asa = 1; aop = 2'b01; pwc = 1; psrc = 2'b01; end
      9:  begin pw = 1; psrc = 2'b10; end
      10: begin asa = 1; asb = 2'b10; end
      11: begin rw = 1; end
      12: begin pw = 1; psrc = 2'b10; rw = 1; rd = 2'b10; p2r = 1; end
      default: ;
    endcase
    return {pw, pwc, iod, mr, mw, irw, m2r, rd, rw, asa, asb, aop, psrc, p2r, ill};
  endfunction

  task automatic build_seq(input logic [5:0] op);
    seq_q = '{0, 1};
    case (op)
      6'b100011: seq_q = '{0, 1, 2, 3, 4};
      6'b101011: seq_q = '{0, 1, 2, 5};
      6'b000000: seq_q = '{0, 1, 6, 7};
      6'b000100: seq_q = '{0, 1, 8};
      6'b000010: seq_q = '{0, 1, 9};
      6'b001000: seq_q = '{0, 1, 10, 11};
      6'b000011: if (JAL_EN) seq_q = '{0, 1, 12};
      default: ;
    endcase
  endtask

  // Entered at a sampling point with the DUT expected in FETCH; leaves at the next FETCH.
  task automatic run_instr(input logic [5:0] op, input int abort_at);
    opcode = op;
    build_seq(op);
    foreach (seq_q[i]) begin
      check($sformatf("state op=%b step%0d", op, i), 32'(state), 32'(seq_q[i]));
      check($sformatf("outs op=%b st=%0d", op, seq_q[i]), 32'(outs), 32'(exp_out(seq_q[i], op)));
      check("pcw_excl", 32'(pc_write & pc_write_cond), 32'd0);
      if (seq_q[i] == abort_at) begin
        rst = 1'b1;
        #1;
        check("rst_abort_state", 32'(state), 32'd0);
        check("rst_abort_outs", 32'(outs), 32'd0);
        @(posedge clk); @(negedge clk);
        check("rst_hold_state", 32'(state), 32'd0);
        check("rst_hold_outs", 32'(outs), 32'd0);
        rst = 1'b0;
        #1;
        check("rst_release_state", 32'(state), 32'd0);
        check("rst_release_outs", 32'(outs), 32'(exp_out(0, op)));
        return;
      end
      @(posedge clk); @(negedge clk);
    end
  endtask

  logic [5:0] legal_ops [7] = '{6'b000000, 6'b100011, 6'b101011, 6'b000100,
                                6'b000010, 6'b001000, 6'b000011};

  initial begin
    rst = 1'b1;
    opcode = 6'b000000;
    @(negedge clk);
    check("rst_state", 32'(state), 32'd0);
    check("rst_outs", 32'(outs), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("post_rst_state", 32'(state), 32'd0);
    check("post_rst_outs", 32'(outs), 32'(exp_out(0, 6'b000000)));

    run_instr(6'b100011, -1);
    run_instr(6'b101011, -1);
    run_instr(6'b000000, -1);
    run_instr(6'b000100, -1);
    run_instr(6'b000010, -1);
    run_instr(6'b111111, -1);
    run_instr(6'b000011, -1);
    run_instr(6'b001000, -1);
    run_instr(6'b100011, 3);
    run_instr(6'b100011, -1);

    for (int n = 0; n < 300; n++) begin
      logic [5:0] op;
      if ($urandom_range(0, 9) < 7) op = legal_ops[$urandom_range(0, 6)];
      else                          op = 6'($urandom);
      run_instr(op, ($urandom_range(0, 39) == 0) ? int'($urandom_range(0, 4)) : -1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
